pll_lock_qualifier: RTL and testbench
=====================================

// Module: pll_lock_qualifier
// PURPOSE
//  Qualifies the raw asynchronous PLL lock indicator and produces the clean level enable consumed by the power-on
//  reset generator. Synchronises lock, requires it to be stable before asserting en, filters short lock drop-outs,
//  pulses a PLL reset request if lock never arrives, and keeps a sticky loss-of-lock record for status readback.
// PARAMETERS
//  SYNC_STAGES    2      synchroniser depth on lock_async (>=2)
//  LOCK_CYCLES    1024   consecutive synced-high cycles required before en asserts (>=1)
//  UNLOCK_CYCLES  4      consecutive synced-low cycles required before en deasserts (>=1)
//  TIMEOUT_CYCLES 65536  cycles in IDLE without lock before a PLL reset request (>=1)
//  RETRY_PULSE    8      width of pll_reset pulse in cycles (>=1)
// PORTS
//  clk         in   1  system clock
//  areset      in   1  asynchronous reset, active high
//  lock_async  in   1  raw PLL lock, asynchronous to clk
//  clear       in   1  synchronous clear of lock_lost / loss_count
//  en          out  1  qualified lock, level; drives reset generator enable
//  pll_reset   out  1  PLL reset request, active high
//  lock_lost   out  1  sticky: a qualified lock has been lost since last clear
//  loss_count  out  8  saturating count of qualified lock losses
// BEHAVIOUR
//  - Reset is asynchronous and active high. On areset: all sync flops 0, state IDLE, ctr 0, and all outputs 0.
//  - lock_s = last synchroniser stage. A single counter ctr, CTR_WIDTH = $clog2(max of LOCK/TIMEOUT/UNLOCK/RETRY).
//    ctr is set to 0 on every state change.
//  - All outputs are flops and update on the same edge as the state.
//  - State IDLE: en=0. lock_s=1 -> QUALIFY. Otherwise ctr++; at ctr==TIMEOUT_CYCLES-1 -> PLL_RST.
//  - State QUALIFY: lock_s=0 -> IDLE. Otherwise ctr++; at ctr==LOCK_CYCLES-1 -> LOCKED (en<=1).
//  - State LOCKED: en=1. lock_s=0 -> LOSING.
//  - State LOSING: en stays 1. lock_s=1 -> LOCKED. Otherwise ctr++; at ctr==UNLOCK_CYCLES-1 -> IDLE.
//    On that IDLE transition: en<=0, lock_lost<=1, and loss_count increments, saturating at 255.
//  - State PLL_RST: pll_reset=1 and lock_s is ignored. ctr++; at ctr==RETRY_PULSE-1 -> IDLE (pll_reset<=0).
//    The pulse is exactly RETRY_PULSE cycles.
//  - Latency, lock rise -> en rise: SYNC_STAGES+LOCK_CYCLES+1 edges.
//  - Latency, lock fall -> en fall: SYNC_STAGES+UNLOCK_CYCLES+1 edges.
//  - Any synced low run shorter than UNLOCK_CYCLES never drops en.
//  - A low during QUALIFY restarts qualification from IDLE. No partial credit is kept.
//  - clear zeroes lock_lost and loss_count next edge.
//  - clear coincident with a loss event: the loss event wins, giving lock_lost=1 and loss_count=1.
//  - areset mid-operation: en and pll_reset drop immediately (asynchronously), statistics are cleared, and
//    qualification restarts from IDLE after release.
// STRUCTURE
//  - Shared package reset_pkg: typedef enum logic [2:0] {IDLE, QUALIFY, LOCKED, LOSING, PLL_RST} lockq_state_t;
//    it also holds LOSS_COUNT_WIDTH = 8.
//  - Sub-module bit_synchroniser (#(STAGES), clk, areset, d, q) holds the lock_async crossing and is reusable
//    elsewhere.
//  - FSM, counter and status registers are in this module.
// TESTING (SYNC=2, LOCK=16, UNLOCK=4, TIMEOUT=64, RETRY=8)
//  1. Release areset, lock_async=1 throughout -> en rises on edge 19, pll_reset never asserts, loss_count=0.
//  2. lock high 10 cycles, then low -> en stays 0 and the FSM returns to IDLE.
//     Relock held 16+ cycles -> en rises 19 edges after the rise.
//  3. LOCKED, 3-cycle low glitch -> en stays 1, lock_lost=0.
//     Then a 6-cycle low -> en falls 7 edges after the fall, lock_lost=1, loss_count=1.
//  4. lock held low from reset -> pll_reset high on edges 64..71 and low at edge 72.
//     The pulse repeats every 72 cycles. Lock arriving during a pulse is ignored until IDLE.
//  5. 260 qualified lose/relock cycles -> loss_count saturates at 255.
//     clear on the same edge as a loss -> loss_count=1, lock_lost=1.
//  6. areset pulsed (not clock-aligned) while LOCKED with loss_count=3 -> en=0 and all outputs 0 before the next
//     edge. After release with lock held, en returns on edge 19.

Source files
------------

// File: rtl/reset_pkg.sv
// reset_pkg: shared types and widths for the reset/clocking blocks
package reset_pkg;

    localparam int LOSS_COUNT_WIDTH = 8;

    typedef enum logic [2:0] {IDLE, QUALIFY, LOCKED, LOSING, PLL_RST} lockq_state_t;

endpackage

// File: rtl/bit_synchroniser.sv
// bit_synchroniser: multi-flop crossing of a single asynchronous bit into clk
module bit_synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    // shift the raw bit through the flop chain
    always_ff @(posedge clk or posedge areset)
        if (areset) sync <= '0;
        else        sync <= {sync[STAGES-2:0], d};

    assign q = sync[STAGES-1];

endmodule

// File: rtl/pll_lock_qualifier.sv
// pll_lock_qualifier: debounces PLL lock into en, requests PLL reset on timeout, records losses
module pll_lock_qualifier
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_CYCLES    = 1024,
    parameter int UNLOCK_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int RETRY_PULSE    = 8
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        lock_async,
    input  logic                        clear,
    output logic                        en,
    output logic                        pll_reset,
    output logic                        lock_lost,
    output logic [LOSS_COUNT_WIDTH-1:0] loss_count
);

    localparam int MAX_LU    = LOCK_CYCLES > UNLOCK_CYCLES ? LOCK_CYCLES : UNLOCK_CYCLES;
    localparam int MAX_TR    = TIMEOUT_CYCLES > RETRY_PULSE ? TIMEOUT_CYCLES : RETRY_PULSE;
    localparam int MAX_ALL   = MAX_LU > MAX_TR ? MAX_LU : MAX_TR;
    localparam int CTR_WIDTH = $clog2(MAX_ALL) < 1 ? 1 : $clog2(MAX_ALL);

    localparam logic [CTR_WIDTH-1:0] LOCK_END    = CTR_WIDTH'(LOCK_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] UNLOCK_END  = CTR_WIDTH'(UNLOCK_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] TIMEOUT_END = CTR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] RETRY_END   = CTR_WIDTH'(RETRY_PULSE - 1);

    lockq_state_t                state, next_state;
    logic [CTR_WIDTH-1:0]        ctr;
    logic                        lock_s, en_d, pll_reset_d, lost_d;
    logic [LOSS_COUNT_WIDTH-1:0] count_d;

    bit_synchroniser #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .areset (areset),
        .d      (lock_async),
        .q      (lock_s)
    );

    // state, dwell counter and registered control outputs
    always_ff @(posedge clk or posedge areset)
        if (areset) begin
            state     <= IDLE;
            ctr       <= '0;
            en        <= 1'b0;
            pll_reset <= 1'b0;
        end else begin
            state     <= next_state;
            ctr       <= (next_state != state || state == LOCKED) ? '0 : ctr + 1'b1;
            en        <= en_d;
            pll_reset <= pll_reset_d;
        end

    // transitions; a dropped lock in QUALIFY throws away all accumulated credit
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = lock_s ? QUALIFY : (ctr == TIMEOUT_END ? PLL_RST : IDLE);
            QUALIFY: next_state = !lock_s ? IDLE : (ctr == LOCK_END ? LOCKED : QUALIFY);
            LOCKED:  next_state = lock_s ? LOCKED : LOSING;
            LOSING:  next_state = lock_s ? LOCKED : (ctr == UNLOCK_END ? IDLE : LOSING);
            PLL_RST: next_state = ctr == RETRY_END ? IDLE : PLL_RST;
            default: next_state = IDLE;
        endcase
    end

    // next output values; a loss event outranks a coincident clear
    always_comb begin
        en_d        = next_state == LOCKED || next_state == LOSING;
        pll_reset_d = next_state == PLL_RST;
        lost_d      = clear ? 1'b0 : lock_lost;
        count_d     = clear ? '0 : loss_count;
        if (state == LOSING && next_state == IDLE) begin
            lost_d  = 1'b1;
            count_d = clear ? LOSS_COUNT_WIDTH'(1) : (&loss_count ? loss_count : loss_count + 1'b1);
        end
    end

    // sticky loss status
    always_ff @(posedge clk or posedge areset)
        if (areset) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            lock_lost  <= lost_d;
            loss_count <= count_d;
        end

endmodule

// File: tb/tb_pll_lock_qualifier.sv
// tb_pll_lock_qualifier: directed checks of lock qualification, filtering, retry and statistics
module tb_pll_lock_qualifier;
    import reset_pkg::*;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       lock_async = 1'b0;
    logic       clear = 1'b0;
    logic       en, pll_reset, lock_lost;
    logic [7:0] loss_count;
    int         errors = 0;
    int         checks = 0;
    int         exp_cnt;

    pll_lock_qualifier #(
        .SYNC_STAGES    (2),
        .LOCK_CYCLES    (16),
        .UNLOCK_CYCLES  (4),
        .TIMEOUT_CYCLES (64),
        .RETRY_PULSE    (8)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .lock_async (lock_async),
        .clear      (clear),
        .en         (en),
        .pll_reset  (pll_reset),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart(input logic lock_level);
        @(posedge clk);
        #1;
        areset = 1'b1;
        lock_async = lock_level;
        clear = 1'b0;
        step(2);
        areset = 1'b0;
    endtask

    task automatic lose_and_relock();
        lock_async = 1'b0;
        step(7);
        lock_async = 1'b1;
        step(19);
    endtask

    initial begin
        #12;
        check("reset_en", 32'(en), 0);
        check("reset_pll_reset", 32'(pll_reset), 0);
        check("reset_lock_lost", 32'(lock_lost), 0);
        check("reset_loss_count", 32'(loss_count), 0);
        check("reset_state", 32'(dut.state), 32'(IDLE));

        restart(1'b1);
        step(18);
        check("t1_en_edge18", 32'(en), 0);
        step(1);
        check("t1_en_edge19", 32'(en), 1);
        check("t1_pll_reset", 32'(pll_reset), 0);
        check("t1_loss_count", 32'(loss_count), 0);

        restart(1'b1);
        step(10);
        lock_async = 1'b0;
        step(3);
        check("t2_state_idle", 32'(dut.state), 32'(IDLE));
        check("t2_en_low", 32'(en), 0);
        lock_async = 1'b1;
        step(18);
        check("t2_relock_edge18", 32'(en), 0);
        step(1);
        check("t2_relock_edge19", 32'(en), 1);

        lock_async = 1'b0;
        step(3);
        lock_async = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_glitch_en", 32'(en), 1);
            step(1);
        end
        check("t3_glitch_lock_lost", 32'(lock_lost), 0);
        lock_async = 1'b0;
        step(6);
        check("t3_loss_en_edge6", 32'(en), 1);
        lock_async = 1'b1;
        step(1);
        check("t3_loss_en_edge7", 32'(en), 0);
        check("t3_lock_lost", 32'(lock_lost), 1);
        check("t3_loss_count", 32'(loss_count), 1);

        restart(1'b0);
        step(63);
        check("t4_pll_reset_edge63", 32'(pll_reset), 0);
        step(1);
        check("t4_pll_reset_edge64", 32'(pll_reset), 1);
        step(7);
        check("t4_pll_reset_edge71", 32'(pll_reset), 1);
        step(1);
        check("t4_pll_reset_edge72", 32'(pll_reset), 0);
        step(63);
        check("t4_pll_reset_edge135", 32'(pll_reset), 0);
        step(1);
        check("t4_pll_reset_edge136", 32'(pll_reset), 1);
        step(1);
        lock_async = 1'b1;
        step(6);
        check("t4_pulse_ignores_lock", 32'(pll_reset), 1);
        check("t4_state_pll_rst", 32'(dut.state), 32'(PLL_RST));
        check("t4_en_during_pulse", 32'(en), 0);
        step(1);
        check("t4_pulse_end", 32'(pll_reset), 0);
        check("t4_state_idle", 32'(dut.state), 32'(IDLE));
        step(1);
        check("t4_state_qualify", 32'(dut.state), 32'(QUALIFY));
        step(15);
        check("t4_en_edge160", 32'(en), 0);
        step(1);
        check("t4_en_edge161", 32'(en), 1);

        exp_cnt = 0;
        for (int i = 0; i < 260; i++) begin
            lose_and_relock();
            exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
            check("t5_loss_count", 32'(loss_count), 32'(exp_cnt));
        end
        check("t5_saturated", 32'(loss_count), 255);
        check("t5_en_relocked", 32'(en), 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t5_clear_lock_lost", 32'(lock_lost), 0);
        check("t5_clear_loss_count", 32'(loss_count), 0);
        lose_and_relock();
        lose_and_relock();
        check("t5_count_after_clear", 32'(loss_count), 2);
        lock_async = 1'b0;
        step(6);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t5_coincident_count", 32'(loss_count), 1);
        check("t5_coincident_lost", 32'(lock_lost), 1);
        check("t5_coincident_en", 32'(en), 0);

        lock_async = 1'b1;
        step(19);
        check("t6_relock", 32'(en), 1);
        lose_and_relock();
        lose_and_relock();
        check("t6_count3", 32'(loss_count), 3);
        check("t6_locked", 32'(en), 1);
        #2;
        areset = 1'b1;
        #1;
        check("t6_async_en", 32'(en), 0);
        check("t6_async_pll_reset", 32'(pll_reset), 0);
        check("t6_async_lock_lost", 32'(lock_lost), 0);
        check("t6_async_loss_count", 32'(loss_count), 0);
        #3;
        areset = 1'b0;
        step(18);
        check("t6_en_edge18", 32'(en), 0);
        step(1);
        check("t6_en_edge19", 32'(en), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
